// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the MAC sequencer
package mac_pkg;
    localparam int WIDTH_DEF = 24;
    localparam int AW_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/mac_seq_agen.sv
// rtl/mac_seq_agen.sv - pair counter and operand address counters for mac_seq
module mac_seq_agen #(
    parameter int AW = mac_pkg::AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          rd_step,
    input  logic          wr_step,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    output logic [AW-1:0] addr0,
    output logic [AW-1:0] addr1,
    output logic          len_zero,
    output logic          last
);
    logic [AW:0] cnt_q;

    // Address counters wrap naturally at AW bits; the pair counter counts write cycles left.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            addr0 <= '0;
            addr1 <= '0;
        end else if (load) begin
            cnt_q <= len;
            addr0 <= base0;
            addr1 <= base1;
        end else begin
            if (rd_step) begin
                addr0 <= addr0 + AW'(1);
                addr1 <= addr1 + AW'(1);
            end
            if (wr_step) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

    assign len_zero = (cnt_q == '0);
    assign last     = (cnt_q == (AW+1)'(1));
endmodule

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequences operand reads into an external MAC and captures the dot product
module mac_seq
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic             Start_SI,
    input  logic [AW:0]      Len_DI,
    input  logic [AW-1:0]    Base0_DI,
    input  logic [AW-1:0]    Base1_DI,
    output logic             Busy_SO,
    output logic             Done_SO,
    output logic [WIDTH-1:0] Res_DO,
    output logic             RdEn_SO,
    output logic [AW-1:0]    RdAddr0_DO,
    output logic [AW-1:0]    RdAddr1_DO,
    input  logic [WIDTH-1:0] RdData0_DI,
    input  logic [WIDTH-1:0] RdData1_DI,
    output logic             MacClr_SO,
    output logic             MacWrEn_SO,
    output logic [WIDTH-1:0] MacIn0_DO,
    output logic [WIDTH-1:0] MacIn1_DO,
    input  logic [WIDTH-1:0] MacOut_DI
);
    state_t state_q, state_d;
    logic   load, len_zero, last;

    mac_seq_agen #(.AW(AW)) u_agen (
        .clk      (Clk_CI),
        .rst      (Rst_RI),
        .load     (load),
        .rd_step  (RdEn_SO),
        .wr_step  (MacWrEn_SO),
        .len      (Len_DI),
        .base0    (Base0_DI),
        .base1    (Base1_DI),
        .addr0    (RdAddr0_DO),
        .addr1    (RdAddr1_DO),
        .len_zero (len_zero),
        .last     (last)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (Start_SI) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = len_zero ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (last) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Reads run one cycle ahead of writes, so the final stream cycle issues no read.
    always_comb begin
        load       = 1'b0;
        RdEn_SO    = 1'b0;
        MacClr_SO  = 1'b0;
        MacWrEn_SO = 1'b0;
        Done_SO    = 1'b0;
        case (state_q)
            ST_IDLE:   load = Start_SI;
            ST_CLEAR: begin
                MacClr_SO = 1'b1;
                RdEn_SO   = ~len_zero;
            end
            ST_STREAM: begin
                MacWrEn_SO = 1'b1;
                RdEn_SO    = ~last;
            end
            ST_DONE:   Done_SO = 1'b1;
            default:   ;
        endcase
    end

    assign Busy_SO   = (state_q != ST_IDLE);
    assign MacIn0_DO = MacWrEn_SO ? RdData0_DI : '0;
    assign MacIn1_DO = MacWrEn_SO ? RdData1_DI : '0;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            Res_DO <= '0;
        end else if (state_q == ST_DRAIN) begin
            Res_DO <= MacOut_DI;
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed self-checking bench for mac_seq with behavioural memories and MAC
module tb_mac_seq;
    localparam int WIDTH = 24;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             Rst_RI, Start_SI;
    logic [AW:0]      Len_DI;
    logic [AW-1:0]    Base0_DI, Base1_DI;
    logic             Busy_SO, Done_SO, RdEn_SO, MacClr_SO, MacWrEn_SO;
    logic [WIDTH-1:0] Res_DO, RdData0_DI, RdData1_DI, MacIn0_DO, MacIn1_DO, MacOut_DI;
    logic [AW-1:0]    RdAddr0_DO, RdAddr1_DO;

    logic [WIDTH-1:0] mem0 [0:255];
    logic [WIDTH-1:0] mem1 [0:255];
    logic [WIDTH-1:0] acc;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [511:0] wr_m, rd_m, clr_m, done_m, busy_m;
    int a0_q[$], a1_q[$], in0_q[$], in1_q[$];
    int done_cyc;
    logic [WIDTH-1:0] res_done;
    bit both_hi;

    mac_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
        .Clk_CI(clk), .Rst_RI(Rst_RI), .Start_SI(Start_SI), .Len_DI(Len_DI),
        .Base0_DI(Base0_DI), .Base1_DI(Base1_DI), .Busy_SO(Busy_SO), .Done_SO(Done_SO),
        .Res_DO(Res_DO), .RdEn_SO(RdEn_SO), .RdAddr0_DO(RdAddr0_DO), .RdAddr1_DO(RdAddr1_DO),
        .RdData0_DI(RdData0_DI), .RdData1_DI(RdData1_DI), .MacClr_SO(MacClr_SO),
        .MacWrEn_SO(MacWrEn_SO), .MacIn0_DO(MacIn0_DO), .MacIn1_DO(MacIn1_DO),
        .MacOut_DI(MacOut_DI)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RdEn_SO) begin
            RdData0_DI <= mem0[RdAddr0_DO];
            RdData1_DI <= mem1[RdAddr1_DO];
        end
        if (MacClr_SO) acc <= '0;
        else if (MacWrEn_SO) acc <= acc + MacIn0_DO * MacIn1_DO;
    end
    assign MacOut_DI = acc;

    // Cycle 0 is the cycle in which Start_SI is first sampled; caller is just past a rising edge.
    task automatic run_job(input int len, input int b0, input int b1, input bit hold,
                           input int pulse_cyc, input int rst_cyc, input int ncyc, input bit stop_done);
        wr_m = '0; rd_m = '0; clr_m = '0; done_m = '0; busy_m = '0;
        a0_q.delete(); a1_q.delete(); in0_q.delete(); in1_q.delete();
        done_cyc = -1; res_done = '0; both_hi = 1'b0;
        Len_DI = len[AW:0];
        Base0_DI = b0[AW-1:0];
        Base1_DI = b1[AW-1:0];
        Start_SI = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            wr_m[k] = MacWrEn_SO; rd_m[k] = RdEn_SO; clr_m[k] = MacClr_SO;
            done_m[k] = Done_SO; busy_m[k] = Busy_SO;
            if (RdEn_SO) begin a0_q.push_back(int'(RdAddr0_DO)); a1_q.push_back(int'(RdAddr1_DO)); end
            if (MacWrEn_SO) begin in0_q.push_back(int'(MacIn0_DO)); in1_q.push_back(int'(MacIn1_DO)); end
            if (Done_SO && done_cyc < 0) begin done_cyc = k; res_done = Res_DO; end
            if (MacClr_SO && MacWrEn_SO) both_hi = 1'b1;
            @(posedge clk); #1;
            Start_SI = hold || (k + 1 == pulse_cyc);
            Rst_RI = (k + 1 == rst_cyc);
            if (stop_done && done_cyc >= 0) break;
        end
        Start_SI = 1'b0;
        Rst_RI = 1'b0;
    endtask

    task automatic test_reset();
        Rst_RI = 1'b1; Start_SI = 1'b1; Len_DI = 9'd4; Base0_DI = 8'd7; Base1_DI = 8'd9;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({Busy_SO, Done_SO, RdEn_SO, MacClr_SO, MacWrEn_SO} !== 5'b0)
                $display("FAIL reset_ctrl cyc%0d got=%b exp=00000", c, {Busy_SO, Done_SO, RdEn_SO, MacClr_SO, MacWrEn_SO});
            else pass_cnt++;
            total_cnt++;
            if ({RdAddr0_DO, RdAddr1_DO, MacIn0_DO, MacIn1_DO} !== '0)
                $display("FAIL reset_data cyc%0d got=%h exp=0", c, {RdAddr0_DO, RdAddr1_DO, MacIn0_DO, MacIn1_DO});
            else pass_cnt++;
            total_cnt++;
            if (Res_DO !== '0) $display("FAIL reset_res cyc%0d got=%0d exp=0", c, Res_DO);
            else pass_cnt++;
            @(posedge clk);
        end
        #1;
        Start_SI = 1'b0;
        Rst_RI = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [511:0] e;
        int errs;
        for (int i = 0; i < 4; i++) begin mem0[i] = WIDTH'(i + 1); mem1[i] = WIDTH'(i + 5); end
        run_job(4, 0, 0, 0, -1, -1, 20, 1);
        e = '0; e[5:2] = '1;
        total_cnt++; if (wr_m !== e) $display("FAIL basic_wr got=%h exp=%h", wr_m, e); else pass_cnt++;
        e = '0; e[4:1] = '1;
        total_cnt++; if (rd_m !== e) $display("FAIL basic_rd got=%h exp=%h", rd_m, e); else pass_cnt++;
        e = '0; e[1] = 1'b1;
        total_cnt++; if (clr_m !== e) $display("FAIL basic_clr got=%h exp=%h", clr_m, e); else pass_cnt++;
        e = '0; e[7:1] = '1;
        total_cnt++; if (busy_m !== e) $display("FAIL basic_busy got=%h exp=%h", busy_m, e); else pass_cnt++;
        total_cnt++; if (done_cyc !== 7) $display("FAIL basic_done_cyc got=%0d exp=7", done_cyc); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd70) $display("FAIL basic_res got=%0d exp=70", res_done); else pass_cnt++;
        errs = 0;
        if (in0_q.size() != 4 || a0_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++)
            if (in0_q[i] != i + 1 || in1_q[i] != i + 5 || a0_q[i] != i || a1_q[i] != i) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL basic_operands got=%0d bad exp=0", errs); else pass_cnt++;
        total_cnt++; if (both_hi !== 1'b0) $display("FAIL basic_clr_wr_overlap got=%b exp=0", both_hi); else pass_cnt++;
    endtask

    task automatic test_len0();
        logic [511:0] e;
        run_job(0, 0, 0, 0, -1, -1, 20, 1);
        e = '0; e[1] = 1'b1;
        total_cnt++; if (clr_m !== e) $display("FAIL len0_clr got=%h exp=%h", clr_m, e); else pass_cnt++;
        total_cnt++; if ((rd_m | wr_m) !== '0) $display("FAIL len0_rd_wr got=%h exp=0", rd_m | wr_m); else pass_cnt++;
        total_cnt++; if (done_cyc !== 3) $display("FAIL len0_done_cyc got=%0d exp=3", done_cyc); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd0) $display("FAIL len0_res got=%0d exp=0", res_done); else pass_cnt++;
    endtask

    task automatic test_len1_overflow();
        logic [511:0] e;
        mem0[0] = 24'hFFFFFF; mem1[0] = 24'd2;
        run_job(1, 0, 0, 0, -1, -1, 20, 1);
        e = '0; e[1] = 1'b1;
        total_cnt++; if (rd_m !== e) $display("FAIL len1_rd got=%h exp=%h", rd_m, e); else pass_cnt++;
        e = '0; e[2] = 1'b1;
        total_cnt++; if (wr_m !== e) $display("FAIL len1_wr got=%h exp=%h", wr_m, e); else pass_cnt++;
        total_cnt++; if (done_cyc !== 4) $display("FAIL len1_done_cyc got=%0d exp=4", done_cyc); else pass_cnt++;
        total_cnt++; if (res_done !== 24'hFFFFFE) $display("FAIL len1_res got=%h exp=fffffe", res_done); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int errs;
        int exp0[4] = '{254, 255, 0, 1};
        mem0[254] = 24'd2; mem0[255] = 24'd3; mem0[0] = 24'd1; mem0[1] = 24'd2;
        for (int i = 0; i < 4; i++) mem1[i] = WIDTH'(i + 5);
        run_job(4, 254, 0, 0, -1, -1, 20, 1);
        errs = 0;
        if (a0_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++) if (a0_q[i] != exp0[i] || a1_q[i] != i) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL wrap_addr got=%0d bad exp=0", errs); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd51) $display("FAIL wrap_res got=%0d exp=51", res_done); else pass_cnt++;
    endtask

    task automatic test_full_len();
        int errs;
        for (int i = 0; i < 256; i++) begin mem0[i] = WIDTH'(i); mem1[i] = 24'd1; end
        run_job(256, 0, 0, 0, -1, -1, 300, 1);
        errs = 0;
        if (a0_q.size() != 256) errs++;
        else for (int i = 0; i < 256; i++) if (a0_q[i] != i) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL full_addr got=%0d bad exp=0", errs); else pass_cnt++;
        total_cnt++; if (in0_q.size() !== 256) $display("FAIL full_wr_count got=%0d exp=256", in0_q.size()); else pass_cnt++;
        total_cnt++; if (done_cyc !== 259) $display("FAIL full_done_cyc got=%0d exp=259", done_cyc); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd32640) $display("FAIL full_res got=%0d exp=32640", res_done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [511:0] e;
        int k;
        mem0[0] = 24'd1; mem0[1] = 24'd2; mem1[0] = 24'd5; mem1[1] = 24'd6;
        run_job(2, 0, 0, 1, -1, -1, 16, 0);
        e = '0; e[1] = 1'b1; e[7] = 1'b1; e[13] = 1'b1;
        total_cnt++; if (clr_m !== e) $display("FAIL b2b_clr got=%h exp=%h", clr_m, e); else pass_cnt++;
        e = '0; e[5] = 1'b1; e[11] = 1'b1;
        total_cnt++; if (done_m !== e) $display("FAIL b2b_done got=%h exp=%h", done_m, e); else pass_cnt++;
        e = '0; e[5:1] = '1; e[11:7] = '1; e[15:13] = '1;
        total_cnt++; if (busy_m !== e) $display("FAIL b2b_busy got=%h exp=%h", busy_m, e); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd17) $display("FAIL b2b_res got=%0d exp=17", res_done); else pass_cnt++;
        k = 0;
        while (Busy_SO && k < 10) begin @(posedge clk); #1; k++; end
        total_cnt++; if (Busy_SO !== 1'b0) $display("FAIL b2b_drain_timeout got=%b exp=0", Busy_SO); else pass_cnt++;
        total_cnt++; if (Res_DO !== 24'd17) $display("FAIL b2b_res3 got=%0d exp=17", Res_DO); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        logic [511:0] e;
        for (int i = 0; i < 4; i++) begin mem0[i] = WIDTH'(i + 1); mem1[i] = WIDTH'(i + 5); end
        run_job(4, 0, 0, 0, 3, -1, 10, 0);
        e = '0; e[1] = 1'b1;
        total_cnt++; if (clr_m !== e) $display("FAIL ign_clr got=%h exp=%h", clr_m, e); else pass_cnt++;
        e = '0; e[7:1] = '1;
        total_cnt++; if (busy_m !== e) $display("FAIL ign_busy got=%h exp=%h", busy_m, e); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd70) $display("FAIL ign_res got=%0d exp=70", res_done); else pass_cnt++;
    endtask

    task automatic test_reset_mid_job();
        logic [511:0] e;
        for (int i = 0; i < 4; i++) begin mem0[i] = WIDTH'(i + 1); mem1[i] = WIDTH'(i + 5); end
        run_job(4, 0, 0, 0, -1, 3, 8, 0);
        e = '0; e[3:1] = '1;
        total_cnt++; if (busy_m !== e) $display("FAIL rstmid_busy got=%h exp=%h", busy_m, e); else pass_cnt++;
        total_cnt++; if (done_m !== '0) $display("FAIL rstmid_done got=%h exp=0", done_m); else pass_cnt++;
        mem0[0] = 24'd3; mem0[1] = 24'd4; mem1[0] = 24'd5; mem1[1] = 24'd6;
        run_job(2, 0, 0, 0, -1, -1, 20, 1);
        e = '0; e[1] = 1'b1;
        total_cnt++; if (clr_m !== e) $display("FAIL rstmid_clr2 got=%h exp=%h", clr_m, e); else pass_cnt++;
        total_cnt++; if (done_cyc !== 5) $display("FAIL rstmid_done_cyc got=%0d exp=5", done_cyc); else pass_cnt++;
        total_cnt++; if (res_done !== 24'd39) $display("FAIL rstmid_res got=%0d exp=39", res_done); else pass_cnt++;
    endtask

    initial begin
        Rst_RI = 1'b0; Start_SI = 1'b0; Len_DI = '0; Base0_DI = '0; Base1_DI = '0;
        test_reset();
        test_basic();
        test_len0();
        test_len1_overflow();
        test_wrap();
        test_full_len();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter WIDTH, default 24: operand, MAC and result width in bits.
REQ-002 Parameter AW, default 8: operand-memory address width; Len_DI is AW+1 bits.
REQ-003 Clk_CI  in  1  single clock; all state updates on rising edge.
REQ-004 Rst_RI  in  1  reset, synchronous, active-high.
REQ-005 Start_SI  in  1  job request; sampled only in IDLE.
REQ-006 Len_DI  in  AW+1  number of operand pairs, 0..2^AW.
REQ-007 Base0_DI, Base1_DI  in  AW each  start addresses of operand vectors 0 and 1.
REQ-008 Busy_SO  out  1  high in every state except IDLE.
REQ-009 Done_SO  out  1  one-cycle pulse; Res_DO is valid in that cycle.
REQ-010 Res_DO  out  WIDTH  last captured dot product; held until the next job's DONE.
REQ-011 RdEn_SO  out  1  operand-memory read strobe; data returns the following cycle.
REQ-012 RdAddr0_DO, RdAddr1_DO  out  AW each  read addresses.
REQ-013 RdData0_DI, RdData1_DI  in  WIDTH each  read data, valid one cycle after RdEn_SO.
REQ-014 MacClr_SO, MacWrEn_SO  out  1 each  drive the MAC clear and write-enable.
REQ-015 MacIn0_DO, MacIn1_DO  out  WIDTH each  MAC operands, valid when MacWrEn_SO is high.
REQ-016 MacOut_DI  in  WIDTH  MAC accumulator; reflects a Clr/WrEn one cycle after it is sampled.

Function
REQ-017 FSM states IDLE, CLEAR, STREAM, DRAIN, DONE; cycle numbering below takes the Start_SI sample cycle as cycle 0.
REQ-018 IDLE: Start_SI=1 latches Len_DI, Base0_DI and Base1_DI, then goes to CLEAR; Start_SI is ignored in all other states.
REQ-019 CLEAR (cycle 1): MacClr_SO=1 for exactly one cycle; if Len>0, RdEn_SO=1 at Base0/Base1 and next state is STREAM, else next state is DRAIN.
REQ-020 STREAM (cycles 2..Len+1): MacWrEn_SO=1 every cycle, with MacIn0/1_DO = RdData0/1_DI combinationally or a zero-latency pass.
REQ-021 STREAM: RdEn_SO=1 with address base+i in cycle i+1 for i=1..Len-1; no read is issued in the final STREAM cycle.
REQ-022 Exactly Len WrEn cycles per job, contiguous, with no bubbles.
REQ-023 Addresses increment modulo 2^AW.
REQ-024 DRAIN (cycle Len+2): Res_DO <= MacOut_DI, then go to DONE.
REQ-025 DONE (cycle Len+3): Done_SO=1, then go to IDLE.
REQ-026 A new Start_SI is accepted from the cycle after DONE.
REQ-027 MacClr_SO and MacWrEn_SO are never both high.
REQ-028 RdEn_SO, MacWrEn_SO and MacClr_SO are low in IDLE, DRAIN and DONE.
REQ-029 Arithmetic overflow is the MAC's concern; mac_seq passes MacOut_DI through unchanged (mod 2^WIDTH).
REQ-030 Len=2^AW reads every address exactly once.

Reset
REQ-031 With Rst_RI=1 at a clock edge: FSM=IDLE, Res_DO=0, Busy_SO=0, Done_SO=0, RdEn_SO=0, MacClr_SO=0, MacWrEn_SO=0, all address and operand outputs 0.
REQ-032 Reset in any state aborts the job with no Done_SO pulse; the next job proceeds normally and begins with its own CLEAR.
REQ-033 Reset has priority over Start_SI.

Structure
REQ-034 Shared package mac_pkg holds the state encoding, WIDTH_DEF=24 and AW_DEF=8.
REQ-035 One sub-module, mac_seq_agen, holds the pair counter and the two address counters (load, increment, last-flag); the FSM stays in mac_seq.

Verification
REQ-036 Reset: hold Rst_RI high for 2 cycles with Start_SI=1 -> all outputs 0 and Busy_SO=0 throughout.
REQ-037 Len=4, mem0=[1,2,3,4], mem1=[5,6,7,8], behavioural MAC -> WrEn high in cycles 2-5, Done_SO in cycle 7, Res_DO=70.
REQ-038 Len=0 -> MacClr in cycle 1, no RdEn or WrEn, Done_SO in cycle 3, Res_DO=0.
REQ-039 Base0=254, Base1=0, Len=4, AW=8 -> RdAddr0 sequence 254,255,0,1 and RdAddr1 sequence 0,1,2,3.
REQ-040 Start_SI held high across a Len=2 job -> jobs run back-to-back with one IDLE cycle between DONE and the next CLEAR; Start_SI pulsed during STREAM is ignored.
REQ-041 Rst_RI pulsed in the 2nd STREAM cycle of a Len=4 job -> next cycle is IDLE with no Done_SO; a following Len=2 job with mem [3,4]x[5,6] gives Res_DO=39.
